// File: rtl/bridge_pkg.sv
// =====================================================================
// bridge_pkg: FSM state types and frame helpers for serial_bus_bridge
// Rev 1.0
// =====================================================================
`default_nettype none

package bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_ISSUE = 2'd1,
        M_WAIT  = 2'd2
    } m_state_t;

    // Start bit + payload + stop bit.
    function automatic int frame_bits(input int data_width);
        return data_width + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// =====================================================================
// sync_fifo: single-clock FIFO; push while full succeeds only with a pop
// Rev 1.0
// =====================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/serial_bus_bridge.sv
// =====================================================================
// serial_bus_bridge: 8N1 serial line <-> bus-node bridge with RX/TX FIFOs
// Rev 1.0
// =====================================================================
`default_nettype none

module serial_bus_bridge #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_LEN  = 6
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          loopback,
    input  logic                          tx_manual,
    input  logic                          tx_manual_val,
    output logic                          m_execute,
    output logic [DATA_WIDTH-1:0]         m_din,
    input  logic                          m_busy,
    input  logic                          s_out_dv,
    input  logic [DATA_WIDTH-1:0]         s_out_data,
    input  logic                          status_clr,
    output logic                          rx_overflow,
    output logic                          tx_overflow,
    output logic                          frame_err,
    output logic                          m_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

    import bridge_pkg::*;

    localparam int CW         = $clog2(CLKS_PER_BIT);
    localparam int BW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FRAME_BITS = frame_bits(DATA_WIDTH);

    logic rx_meta, rx_s;
    rx_state_t rs, rs_nx;
    logic [CW-1:0] rx_cnt;
    logic [BW-1:0] rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic rx_half, rx_tick, rx_last, rx_push, rx_ferr;
    logic rx_full, rx_empty, rx_pop;
    logic [DATA_WIDTH-1:0] rx_head;

    m_state_t ms, ms_nx;
    logic [TIMEOUT_LEN-1:0] m_timer;
    logic m_pop, m_to_set, timer_done, lb_move;

    tx_state_t ts, ts_nx;
    logic [CW-1:0] tx_cnt;
    logic [BW-1:0] tx_bit;
    logic [FRAME_BITS-1:0] tx_shreg;
    logic tx_tick, tx_last, start_ok, tx_load, tx_pop, manual_act;
    logic tx_full, tx_empty, tx_push;
    logic [DATA_WIDTH-1:0] tx_head, tx_din;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------- RX FSM ----------------
    assign rx_half = (rx_cnt == CW'(CLKS_PER_BIT/2 - 1));
    assign rx_tick = (rx_cnt == CW'(CLKS_PER_BIT - 1));
    assign rx_last = (rx_bit == BW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rs <= R_IDLE;
        else       rs <= rs_nx;
    end

    always_comb begin
        rs_nx = rs;
        case (rs)
            R_IDLE:  if (!rx_s) rs_nx = R_START;
            R_START: if (rx_half) rs_nx = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_last) rs_nx = R_STOP;
            R_STOP:  if (rx_tick) rs_nx = R_IDLE;
            default: rs_nx = R_IDLE;
        endcase
    end

    always_comb begin
        rx_push = (rs == R_STOP) && rx_tick && rx_s;
        rx_ferr = (rs == R_STOP) && rx_tick && !rx_s;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rs == R_IDLE || rs_nx != rs || rx_tick) rx_cnt <= '0;
            else                                         rx_cnt <= rx_cnt + 1'b1;
            if (rs == R_IDLE) begin
                rx_bit <= '0;
            end else if (rs == R_DATA && rx_tick) begin
                rx_bit   <= rx_bit + 1'b1;
                rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
            end
        end
    end

    assign rx_pop = m_pop || lb_move;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push), .din(rx_shift), .pop(rx_pop),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    // ---------------- Master FSM ----------------
    assign timer_done = (m_timer == {TIMEOUT_LEN{1'b1}});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ms <= M_IDLE;
        else       ms <= ms_nx;
    end

    always_comb begin
        ms_nx = ms;
        case (ms)
            M_IDLE:  if (!loopback && !rx_empty && !m_busy) ms_nx = M_ISSUE;
            M_ISSUE: if (m_busy) ms_nx = M_WAIT;
                     else if (timer_done) ms_nx = M_IDLE;
            M_WAIT:  if (!m_busy) ms_nx = M_IDLE;
            default: ms_nx = M_IDLE;
        endcase
    end

    // The slave port owns the TX FIFO write port; loopback yields for that cycle.
    always_comb begin
        m_execute = (ms == M_ISSUE);
        m_pop     = (ms == M_IDLE) && !loopback && !rx_empty && !m_busy;
        m_to_set  = (ms == M_ISSUE) && !m_busy && timer_done;
        lb_move   = (ms == M_IDLE) && loopback && !rx_empty && !tx_full && !s_out_dv;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_din   <= '0;
            m_timer <= '0;
        end else begin
            if (m_pop) m_din <= rx_head;
            if (ms != M_ISSUE) m_timer <= '0;
            else               m_timer <= m_timer + 1'b1;
        end
    end

    // ---------------- TX path ----------------
    assign tx_push = s_out_dv || lb_move;
    assign tx_din  = s_out_dv ? s_out_data : rx_head;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push), .din(tx_din), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    assign tx_tick  = (tx_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_last  = (tx_bit == BW'(DATA_WIDTH - 1));
    assign start_ok = !tx_empty && !manual_act && !tx_manual;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ts <= T_IDLE;
        else       ts <= ts_nx;
    end

    always_comb begin
        ts_nx = ts;
        case (ts)
            T_IDLE:  if (start_ok) ts_nx = T_START;
            T_START: if (tx_tick) ts_nx = T_DATA;
            T_DATA:  if (tx_tick && tx_last) ts_nx = T_STOP;
            T_STOP:  if (tx_tick) ts_nx = start_ok ? T_START : T_IDLE;
            default: ts_nx = T_IDLE;
        endcase
    end

    // The word stays at the FIFO head until its payload is out, so it still counts in tx_level.
    always_comb begin
        tx_load = start_ok && ((ts == T_IDLE) || (ts == T_STOP && tx_tick));
        tx_pop  = (ts == T_DATA) && tx_tick && tx_last;
        if (ts == T_IDLE) tx = manual_act ? tx_manual_val : 1'b1;
        else              tx = tx_shreg[0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shreg   <= '1;
            manual_act <= 1'b0;
        end else begin
            if (ts == T_IDLE) manual_act <= tx_manual;
            if (ts == T_IDLE || tx_tick) tx_cnt <= '0;
            else                         tx_cnt <= tx_cnt + 1'b1;
            if (tx_load) begin
                tx_shreg <= {1'b1, tx_head, 1'b0};
                tx_bit   <= '0;
            end else if (tx_tick) begin
                tx_shreg <= {1'b1, tx_shreg[FRAME_BITS-1:1]};
                if (ts == T_DATA) tx_bit <= tx_bit + 1'b1;
            end
        end
    end

    // ---------------- Sticky flags ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_overflow <= 1'b0;
            tx_overflow <= 1'b0;
            frame_err   <= 1'b0;
            m_timeout   <= 1'b0;
        end else begin
            rx_overflow <= (rx_push && rx_full && !rx_pop)    || (rx_overflow && !status_clr);
            tx_overflow <= (s_out_dv && tx_full && !tx_pop)   || (tx_overflow && !status_clr);
            frame_err   <= rx_ferr                            || (frame_err && !status_clr);
            m_timeout   <= m_to_set                           || (m_timeout && !status_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_bus_bridge.sv
// =====================================================================
// tb_serial_bus_bridge: randomized + directed bench with frame-level model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_serial_bus_bridge;

    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam int FD  = 4;
    localparam int TL  = 6;
    localparam int LW  = $clog2(FD) + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx = 1'b1;
    logic loopback = 1'b0;
    logic tx_manual = 1'b0;
    logic tx_manual_val = 1'b1;
    logic m_busy = 1'b0;
    logic s_out_dv = 1'b0;
    logic [DW-1:0] s_out_data = '0;
    logic status_clr = 1'b0;

    logic tx, m_execute, rx_overflow, tx_overflow, frame_err, m_timeout;
    logic [DW-1:0] m_din;
    logic [LW-1:0] rx_level, tx_level;

    serial_bus_bridge #(
        .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD), .TIMEOUT_LEN(TL)
    ) dut (
        .clk(clk), .rstn(rstn), .rx(rx), .tx(tx), .loopback(loopback),
        .tx_manual(tx_manual), .tx_manual_val(tx_manual_val),
        .m_execute(m_execute), .m_din(m_din), .m_busy(m_busy),
        .s_out_dv(s_out_dv), .s_out_data(s_out_data), .status_clr(status_clr),
        .rx_overflow(rx_overflow), .tx_overflow(tx_overflow), .frame_err(frame_err),
        .m_timeout(m_timeout), .rx_level(rx_level), .tx_level(tx_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] m_exp[$];
    logic [7:0] tx_exp[$];
    int tx_starts[$];
    int frames_seen = 0;
    int execs_seen = 0;
    int last_exec_len = 0;
    bit mon_en = 0;
    bit mon_tx_off = 0;
    bit resp_en = 0;
    int resp_extra = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: master words and decoded serial frames against the expected queues.
    initial begin
        int tcnt;
        int elen;
        logic ep;
        logic [9:0] bits;
        tcnt = -1; elen = 0; ep = 1'b0; bits = '0;
        forever begin
            @(negedge clk);
            if (!rstn || !mon_en) begin
                tcnt = -1; elen = 0; ep = 1'b0;
            end else begin
                if (m_execute && !ep) begin
                    execs_seen++;
                    if (m_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_m_execute: got m_din %0h expected no transaction", m_din);
                    end else begin
                        chk("m_din", m_din, m_exp.pop_front());
                    end
                end
                if (m_execute) elen++;
                else if (ep) begin
                    last_exec_len = elen;
                    elen = 0;
                end
                ep = m_execute;

                if (tcnt < 0) begin
                    if (!mon_tx_off && tx === 1'b0) begin
                        tcnt = 0;
                        tx_starts.push_back(cyc);
                    end
                end else begin
                    tcnt++;
                end
                if (tcnt >= 0 && (tcnt % CPB) == CPB/2 - 1) bits[tcnt/CPB] = tx;
                if (tcnt == 9*CPB + CPB/2 - 1) begin
                    chk("tx_start_bit", bits[0], 1'b0);
                    chk("tx_stop_bit", bits[9], 1'b1);
                    if (tx_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_tx_frame: got %0h expected no frame", bits[8:1]);
                    end else begin
                        chk("tx_byte", bits[8:1], tx_exp.pop_front());
                    end
                    frames_seen++;
                    tcnt = -1;
                end
            end
        end
    end

    // Master responder: busy is seen by the DUT on the second edge after m_execute rose.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && m_execute && !m_busy) begin
                repeat (1 + resp_extra) @(negedge clk);
                m_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                m_busy = 1'b0;
                @(negedge clk);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic slave_wr(input logic [7:0] d);
        @(negedge clk);
        s_out_dv = 1'b1;
        s_out_data = d;
        @(negedge clk);
        s_out_dv = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((m_exp.size() != 0 || tx_exp.size() != 0 || rx_level != 0 || tx_level != 0
                || m_busy || m_execute) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drain_in_time"}, (n < budget), 1'b1);
        repeat (200) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int fs;
        int ex0;

        repeat (5) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_m_execute", m_execute, 1'b0);
        chk("reset_m_din", m_din, 8'h00);
        chk("reset_rx_overflow", rx_overflow, 1'b0);
        chk("reset_tx_overflow", tx_overflow, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_m_timeout", m_timeout, 1'b0);
        chk("reset_rx_level", rx_level, 0);
        chk("reset_tx_level", tx_level, 0);
        rstn = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Frame to master with prompt busy
        resp_en = 1; resp_extra = 0;
        m_exp.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("t1", 400);
        chk("t1_exec_len", last_exec_len, 2);
        chk("t1_m_din_hold", m_din, 8'hA5);
        chk("t1_rx_level", rx_level, 0);

        // Bad stop bit
        ex0 = execs_seen;
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        chk("t2_frame_err", frame_err, 1'b1);
        chk("t2_no_exec", execs_seen, ex0);
        chk("t2_rx_level", rx_level, 0);
        pulse_clr();
        chk("t2_frame_err_clr", frame_err, 1'b0);

        // Slave burst overflowing the TX FIFO
        tx_starts.delete();
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            s_out_dv = 1'b1;
            s_out_data = 8'(i);
            if (i <= FD) tx_exp.push_back(8'(i));
            @(negedge clk);
        end
        s_out_dv = 1'b0;
        chk("t3_tx_overflow", tx_overflow, 1'b1);
        chk("t3_tx_level_full", tx_level, 4);
        wait_drain("t3", 1200);
        chk("t3_frame_count", tx_starts.size(), 4);
        for (int i = 1; i < tx_starts.size(); i++)
            chk("t3_frame_spacing", tx_starts[i] - tx_starts[i-1], 160);
        pulse_clr();
        chk("t3_tx_overflow_clr", tx_overflow, 1'b0);

        // Master never answers
        resp_en = 0;
        m_exp.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_drain("t4", 400);
        chk("t4_exec_len", last_exec_len, 64);
        chk("t4_m_timeout", m_timeout, 1'b1);
        chk("t4_rx_level", rx_level, 0);
        pulse_clr();
        chk("t4_m_timeout_clr", m_timeout, 1'b0);

        // Loopback
        ex0 = execs_seen;
        loopback = 1'b1;
        tx_exp.push_back(8'h11);
        tx_exp.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_drain("t5", 800);
        chk("t5_no_exec", execs_seen, ex0);
        loopback = 1'b0;

        // Manual override raised mid-frame
        fs = frames_seen;
        tx_exp.push_back(8'hC3);
        slave_wr(8'hC3);
        repeat (60) @(negedge clk);
        tx_manual_val = 1'b0;
        tx_manual = 1'b1;
        tx_exp.push_back(8'h5A);
        slave_wr(8'h5A);
        for (int n = 0; n < 400 && frames_seen == fs; n++) @(posedge clk);
        chk("t6_first_frame_done", frames_seen, fs + 1);
        mon_tx_off = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_tx_manual_low", tx, 1'b0);
        chk("t6_word_held", tx_level, 1);
        repeat (200) @(negedge clk);
        chk("t6_tx_still_low", tx, 1'b0);
        chk("t6_word_still_held", tx_level, 1);
        tx_manual_val = 1'b1;
        repeat (3) @(negedge clk);
        mon_tx_off = 1'b0;
        tx_manual = 1'b0;
        wait_drain("t6", 400);

        // Randomized: frames to master
        resp_en = 1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            resp_extra = $urandom_range(0, 3);
            m_exp.push_back(b);
            send_frame(b, 1'b1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_drain("rnd_master", 600);

        // Randomized: loopback stream
        loopback = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            tx_exp.push_back(b);
            send_frame(b, 1'b1);
        end
        wait_drain("rnd_loopback", 800);
        loopback = 1'b0;

        // Randomized: slave words
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            tx_exp.push_back(b);
            slave_wr(b);
            repeat ($urandom_range(170, 220)) @(negedge clk);
        end
        wait_drain("rnd_slave", 600);

        chk("end_rx_overflow", rx_overflow, 1'b0);
        chk("end_tx_overflow", tx_overflow, 1'b0);
        chk("end_frame_err", frame_err, 1'b0);
        chk("end_m_timeout", m_timeout, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
